hv_dac_sequencer: RTL and testbench
===================================

HV_DAC_SEQUENCER -- requirements
Module: hv_dac_sequencer

Interface
REQ-001 Parameter TIMEOUT_CYC, default 16'd50000, clk cycles allowed from hv_start to dac_end before abort.
REQ-002 Parameter MAX_RETRY, default 2, re-programming attempts after an error before giving up.
REQ-003 reset  in  1  asynchronous, active-low; all state clears while low.
REQ-004 clk  in  1  system clock; single clock domain, all registers posedge clk.
REQ-005 wr_en  in  1  host write strobe, one word per cycle.
REQ-006 wr_addr  in  3  channel index for write.
REQ-007 wr_data  in  10  channel HV setpoint.
REQ-008 update_req  in  1  one-cycle pulse: program all 8 channels.
REQ-009 f_cnt  in  3  channel index currently addressed by the DAC driver.
REQ-010 dac_end  in  1  driver end-of-sequence level, derived-clock domain.
REQ-011 dac_err_reg  in  8  driver per-channel readback error flags.
REQ-012 ram_data_out  out  10  active setpoint for channel f_cnt.
REQ-013 hv_start  out  1  start request to DAC driver.
REQ-014 busy  out  1  high from accepted request until done or abort.
REQ-015 done  out  1  one-cycle completion pulse.
REQ-016 err_status  out  8  latched dac_err_reg of final attempt.
REQ-017 timeout  out  1  sticky abort flag, cleared by next accepted request.

Function
REQ-018 Two 8x10 banks, shadow and active; wr_en writes shadow[wr_addr] only, in any state.
REQ-019 ram_data_out SHALL equal active[f_cnt] registered, latency 1 clk; active changes only on request acceptance.
REQ-020 States: IDLE, LOAD, START, WAIT, CHECK; encoded, no other reachable states.
REQ-021 IDLE: update_req or pending flag -> LOAD; busy=1, retry_cnt=0, timeout=0, pending=0.
REQ-022 LOAD (1 cycle): active <= shadow (all 8 words), including a wr_en in the same cycle (write-first) -> START.
REQ-023 START: hv_start=1 for exactly 8 clk cycles (two driver sclk periods), timer cleared -> WAIT.
REQ-024 dac_end SHALL pass a 2-flop synchronizer; WAIT exits on synchronized rising edge -> CHECK.
REQ-025 WAIT: timer increments each cycle; at timer==TIMEOUT_CYC-1 -> IDLE, timeout=1, busy=0, no done pulse.
REQ-026 CHECK (1 cycle): dac_err_reg sampled; nonzero and retry_cnt<MAX_RETRY -> START, retry_cnt+1.
REQ-027 CHECK otherwise -> IDLE; err_status<=sample, done=1 one cycle, busy=0 same cycle.
REQ-028 update_req while not IDLE sets one-deep pending flag; extra requests merge; honoured on return to IDLE.
REQ-029 A dac_end edge outside WAIT SHALL be ignored; a level already high entering WAIT does not count.
REQ-030 retry_cnt width 2 bits; MAX_RETRY=0 means no retries.

Reset
REQ-031 reset low: state=IDLE, both banks 0, ram_data_out=0, hv_start=0, busy=0, done=0, err_status=0, timeout=0, pending=0, synchronizer=0, timers 0.
REQ-032 reset asserted mid-operation SHALL drop hv_start and busy asynchronously; no done pulse after release.

Verification
REQ-033 Write ch0..7 = 10'h001..10'h008, update_req, f_cnt sweep -> ram_data_out follows 1 clk later; hv_start 8 cycles; dac_end edge, err=0 -> done pulse, err_status=8'h00.
REQ-034 dac_err_reg=8'h04 on every attempt -> exactly 3 hv_start bursts, done once, err_status=8'h04.
REQ-035 dac_end never rises, TIMEOUT_CYC=100 -> timeout=1, busy=0 exactly 100 cycles after WAIT entry, no done.
REQ-036 Two update_req and a write to ch3=10'h3FF during busy -> one extra run after done; ram_data_out for ch3 = 10'h3FF only after second LOAD.
REQ-037 reset pulsed low during WAIT -> all outputs 0 immediately; subsequent update_req runs normally with active bank 0.

Source files
------------

// File: rtl/hv_dac_sequencer.sv
// Sequences a high-voltage DAC update: double-buffered setpoints, start burst,
// bounded wait for the driver's end-of-sequence, and retry on readback errors.
module hv_dac_sequencer #(
    parameter logic [15:0] TIMEOUT_CYC = 16'd50000,
    parameter int unsigned MAX_RETRY   = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       wr_en,
    input  logic [2:0] wr_addr,
    input  logic [9:0] wr_data,
    input  logic       update_req,
    input  logic [2:0] f_cnt,
    input  logic       dac_end,
    input  logic [7:0] dac_err_reg,
    output logic [9:0] ram_data_out,
    output logic       hv_start,
    output logic       busy,
    output logic       done,
    output logic [7:0] err_status,
    output logic       timeout
);

    // state | meaning
    // IDLE  | waiting for update_req or a pending request
    // LOAD  | copy shadow bank into active bank
    // START | hold hv_start for 8 cycles
    // WAIT  | wait for synchronized dac_end rising edge, bounded by timer
    // CHECK | evaluate readback errors, retry or finish
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_START = 3'd2,
        S_WAIT  = 3'd3,
        S_CHECK = 3'd4
    } state_t;

    localparam logic [1:0] RETRY_LIM = 2'(MAX_RETRY);

    state_t      state;
    logic [9:0]  shadow [8];
    logic [9:0]  active [8];
    logic [2:0]  burst_cnt;
    logic [15:0] timer;
    logic [1:0]  retry_cnt;
    logic        pending;
    logic [2:0]  end_sync;
    logic        end_rise;

    // [0],[1] are the synchronizer flops, [2] holds the previous synced level
    assign end_rise = end_sync[1] & ~end_sync[2];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) shadow[i] <= '0;
        end else if (wr_en) begin
            shadow[wr_addr] <= wr_data;
        end
    end

    // Active bank copy is write-first so a write landing in LOAD is not lost
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) active[i] <= '0;
            ram_data_out <= '0;
        end else begin
            if (state == S_LOAD) begin
                for (int i = 0; i < 8; i++)
                    active[i] <= (wr_en && wr_addr == 3'(i)) ? wr_data : shadow[i];
            end
            ram_data_out <= active[f_cnt];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) end_sync <= '0;
        else        end_sync <= {end_sync[1:0], dac_end};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            hv_start   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err_status <= '0;
            timeout    <= 1'b0;
            pending    <= 1'b0;
            burst_cnt  <= '0;
            timer      <= '0;
            retry_cnt  <= '0;
        end else begin
            done <= 1'b0;
            if (update_req && state != S_IDLE) pending <= 1'b1;
            case (state)
                S_IDLE: begin
                    if (update_req || pending) begin
                        state     <= S_LOAD;
                        busy      <= 1'b1;
                        retry_cnt <= '0;
                        timeout   <= 1'b0;
                        pending   <= 1'b0;
                    end
                end
                S_LOAD: begin
                    state     <= S_START;
                    hv_start  <= 1'b1;
                    burst_cnt <= 3'd7;
                end
                S_START: begin
                    if (burst_cnt == 3'd0) begin
                        hv_start <= 1'b0;
                        timer    <= '0;
                        state    <= S_WAIT;
                    end else begin
                        burst_cnt <= burst_cnt - 3'd1;
                    end
                end
                S_WAIT: begin
                    if (end_rise) begin
                        state <= S_CHECK;
                    end else if (timer == TIMEOUT_CYC - 16'd1) begin
                        state   <= S_IDLE;
                        timeout <= 1'b1;
                        busy    <= 1'b0;
                    end else begin
                        timer <= timer + 16'd1;
                    end
                end
                S_CHECK: begin
                    if (dac_err_reg != 8'h00 && retry_cnt < RETRY_LIM) begin
                        retry_cnt <= retry_cnt + 2'd1;
                        state     <= S_START;
                        hv_start  <= 1'b1;
                        burst_cnt <= 3'd7;
                    end else begin
                        err_status <= dac_err_reg;
                        done       <= 1'b1;
                        busy       <= 1'b0;
                        state      <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hv_dac_sequencer.sv
// Randomized bench for hv_dac_sequencer: a behavioural DAC driver plus a
// transaction-level model of the setpoint banks, retries and completion.
module tb_hv_dac_sequencer;
    localparam int MAX_RETRY = 2;
    localparam int TMO = 100;

    logic       clk = 1'b0, rst_n = 1'b0;
    logic       wr_en = 1'b0, update_req = 1'b0, dac_end = 1'b0;
    logic [2:0] wr_addr = '0, f_cnt = '0;
    logic [9:0] wr_data = '0;
    logic [7:0] dac_err_reg = '0;
    logic [9:0] ram_data_out;
    logic       hv_start, busy, done, timeout;
    logic [7:0] err_status;

    int checks = 0, errors = 0;
    int bursts = 0, dones = 0;
    bit drv_en = 1'b0;
    logic [9:0] shadow_m [8];
    logic [9:0] active_m [8];

    hv_dac_sequencer #(.TIMEOUT_CYC(16'(TMO)), .MAX_RETRY(MAX_RETRY)) dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .update_req(update_req), .f_cnt(f_cnt), .dac_end(dac_end), .dac_err_reg(dac_err_reg),
        .ram_data_out(ram_data_out), .hv_start(hv_start), .busy(busy), .done(done),
        .err_status(err_status), .timeout(timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // DAC driver model: measures each hv_start burst and answers with dac_end
    initial begin
        int len = 0;
        int dly = 0;
        logic prev = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                len = 0; dly = 0; prev = 1'b0;
            end else begin
                if (hv_start && !prev) dac_end = 1'b0;
                if (hv_start) len++;
                if (!hv_start && prev) begin
                    bursts++;
                    chk("burst_len", len, 8);
                    len = 0;
                    if (drv_en) dly = $urandom_range(1, 12);
                end
                if (dly > 0) begin
                    dly--;
                    if (dly == 0) dac_end = 1'b1;
                end
                if (done) dones++;
                prev = hv_start;
            end
        end
    end

    task automatic write_word(input int a, input logic [9:0] d);
        @(negedge clk);
        wr_en = 1'b1; wr_addr = 3'(a); wr_data = d;
        shadow_m[a] = d;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic pulse_req();
        @(negedge clk);
        update_req = 1'b1;
        @(negedge clk);
        update_req = 1'b0;
    endtask

    task automatic wait_dones(input int target, input int budget);
        int n = 0;
        while (dones < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (dones < target) chk("done_wait", 32'(dones), 32'(target));
    endtask

    task automatic wait_hv(input logic level, input int budget);
        int n = 0;
        while (hv_start !== level && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (hv_start !== level) chk("hv_wait", hv_start, level);
    endtask

    task automatic check_ram(input string tag);
        int prev;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            prev = int'(f_cnt);
            f_cnt = 3'(i);
            #1 chk({tag, "_lat"}, ram_data_out, active_m[prev]);
            @(negedge clk);
            chk(tag, ram_data_out, active_m[i]);
        end
    endtask

    // One complete request with a fixed readback error pattern
    task automatic run(input logic [7:0] err, input string tag);
        int b0, d0, exp_b;
        dac_err_reg = err;
        b0 = bursts; d0 = dones;
        exp_b = (err != 8'h00) ? MAX_RETRY + 1 : 1;
        pulse_req();
        active_m = shadow_m;
        wait_dones(d0 + 1, 2000);
        repeat (20) @(negedge clk);
        chk({tag, "_bursts"}, 32'(bursts - b0), 32'(exp_b));
        chk({tag, "_dones"}, 32'(dones - d0), 1);
        chk({tag, "_err_status"}, err_status, err);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_timeout"}, timeout, 1'b0);
    endtask

    initial begin
        int d0, n;
        for (int i = 0; i < 8; i++) begin shadow_m[i] = '0; active_m[i] = '0; end

        repeat (2) @(negedge clk);
        chk("rst_hv_start", hv_start, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err_status", err_status, 0);
        chk("rst_timeout", timeout, 0);
        chk("rst_ram", ram_data_out, 0);
        rst_n = 1'b1;
        drv_en = 1'b1;

        // Basic run with ramp setpoints
        for (int i = 0; i < 8; i++) write_word(i, 10'(i + 1));
        check_ram("pre_load_ram");
        run(8'h00, "basic");
        check_ram("basic_ram");

        // Persistent channel error: all retries consumed
        run(8'h04, "retry");

        // Write arriving in the LOAD cycle must reach the active bank
        dac_err_reg = 8'h00;
        d0 = dones;
        @(negedge clk); update_req = 1'b1;
        @(negedge clk); update_req = 1'b0;
        wr_en = 1'b1; wr_addr = 3'd5; wr_data = 10'h2AA;
        shadow_m[5] = 10'h2AA;
        active_m = shadow_m;
        @(negedge clk); wr_en = 1'b0;
        wait_dones(d0 + 1, 2000);
        repeat (5) @(negedge clk);
        check_ram("wfirst_ram");

        for (int k = 0; k < 6; k++) begin
            int nw;
            logic [7:0] e;
            nw = $urandom_range(0, 8);
            for (int j = 0; j < nw; j++) write_word($urandom_range(0, 7), 10'($urandom));
            e = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
            run(e, "rand");
            check_ram("rand_ram");
        end

        // Driver never answers: abort exactly TMO cycles after WAIT entry
        drv_en = 1'b0;
        d0 = dones;
        pulse_req();
        active_m = shadow_m;
        wait_hv(1'b1, 50);
        wait_hv(1'b0, 50);
        n = 0;
        while (!timeout && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("tmo_cycles", 32'(n), 32'(TMO));
        chk("tmo_busy", busy, 0);
        repeat (10) @(negedge clk);
        chk("tmo_sticky", timeout, 1);
        chk("tmo_no_done", 32'(dones), 32'(d0));
        drv_en = 1'b1;
        run(8'h00, "after_tmo");

        // Requests and a write during busy: one merged extra run
        write_word(3, 10'h0AA);
        @(negedge clk); f_cnt = 3'd3;
        dac_err_reg = 8'h00;
        d0 = dones;
        pulse_req();
        active_m = shadow_m;
        repeat (4) @(negedge clk);
        pulse_req();
        write_word(3, 10'h3FF);
        pulse_req();
        wait_dones(d0 + 1, 2000);
        chk("pend_old", ram_data_out, 10'h0AA);
        active_m = shadow_m;
        wait_dones(d0 + 2, 2000);
        repeat (40) @(negedge clk);
        chk("pend_new", ram_data_out, 10'h3FF);
        chk("pend_dones", 32'(dones - d0), 2);
        chk("pend_busy", busy, 0);

        // Reset in the middle of WAIT
        drv_en = 1'b0;
        pulse_req();
        active_m = shadow_m;
        wait_hv(1'b1, 50);
        wait_hv(1'b0, 50);
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_hv_start", hv_start, 0);
        chk("arst_busy", busy, 0);
        chk("arst_ram", ram_data_out, 0);
        chk("arst_err_status", err_status, 0);
        chk("arst_timeout", timeout, 0);
        for (int i = 0; i < 8; i++) begin shadow_m[i] = '0; active_m[i] = '0; end
        @(negedge clk);
        rst_n = 1'b1;
        d0 = dones;
        repeat (20) @(negedge clk);
        chk("arst_no_done", 32'(dones), 32'(d0));
        chk("arst_idle_busy", busy, 0);
        drv_en = 1'b1;
        run(8'h00, "post_rst");
        check_ram("post_rst_ram");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got stalled expected finish");
        $fatal(1, "bench time limit");
    end
endmodule
